// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and register-index width.
package pipe_ctrl_pkg;
  localparam int REG_W = 5;

  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t RUN      = 2'd1;
  localparam state_t MEM_WAIT = 2'd2;
  localparam state_t ERROR    = 2'd3;
endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the EX load writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             idex_memrd,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  output logic             load_use
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = idex_memrd && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage write-enables/flushes, dmem handshake, timeout and stall counting.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  input  logic             idex_memrd_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memrd_i,
  input  logic             exmem_memwr_i,
  input  logic             dmem_ack_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             dmem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          load_use;
  logic          mem_op;

  hazard_detect u_hazard (
    .idex_memrd (idex_memrd_i),
    .idex_rd    (idex_rd_i),
    .ifid_rs1   (ifid_rs1_i),
    .ifid_rs2   (ifid_rs2_i),
    .load_use   (load_use)
  );

  assign mem_op     = exmem_memrd_i | exmem_memwr_i;
  assign dmem_req_o = (state == MEM_WAIT);
  assign err_o      = (state == ERROR);

  always_comb begin
    pc_we_o      = 1'b0;
    ifid_we_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    exmem_we_o   = 1'b0;
    memwb_we_o   = 1'b0;
    case (state)
      RUN: begin
        if (mem_op) begin
          // whole pipe frozen until the memory acknowledges
        end else if (load_use) begin
          idex_flush_o = 1'b1;
          exmem_we_o   = 1'b1;
          memwb_we_o   = 1'b1;
        end else begin
          pc_we_o      = 1'b1;
          ifid_we_o    = 1'b1;
          exmem_we_o   = 1'b1;
          memwb_we_o   = 1'b1;
          ifid_flush_o = branch_taken_i;
        end
      end
      MEM_WAIT: begin
        pc_we_o    = dmem_ack_i;
        ifid_we_o  = dmem_ack_i;
        exmem_we_o = dmem_ack_i;
        memwb_we_o = dmem_ack_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN: begin
          tmo_cnt <= '0;
          if (mem_op) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            tmo_cnt <= '0;
            state   <= RUN;
          end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ERROR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if ((state == RUN || state == MEM_WAIT) && !pc_we_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end
endmodule
